branch_pc_unit: RTL



---
 rtl/branch_pc_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/branch_pc_unit.sv
// Program counter with increment/load and a conditional-branch sequencer around the condition flip-flop.
// Latency: inc/load visible 1 cycle after the sampling edge; a branch takes 4 cycles from start to new PC.
// Backpressure: none; pc_load/pc_inc/br_start are accepted only while idle and are dropped while busy.
module branch_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          OFFSET_W = 19
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic [31:0] busIn,
    input  logic [31:0] ir,
    input  logic        pc_load,
    input  logic        pc_inc,
    input  logic        br_start,
    input  logic        con_flag,
    output logic        con_in,
    output logic [31:0] pc,
    output logic        busy,
    output logic        br_done,
    output logic        br_taken
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        SAMPLE = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_r, pc_next;
    logic [31:0] offset_r;
    logic [31:0] offset_sext;
    logic        taken_r;
    logic        offset_cap;
    logic        taken_cap;

    // Only the C field of the IR matters here; the opcode/condition bits feed the condition flip-flop.
    logic unused_ir;
    assign unused_ir = ^ir;

    assign offset_sext = {{(32-OFFSET_W){ir[OFFSET_W-1]}}, ir[OFFSET_W-1:0]};

    // State, PC, latched offset and sampled condition.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            pc_r     <= PC_RESET;
            offset_r <= 32'd0;
            taken_r  <= 1'b0;
        end else begin
            state <= state_next;
            pc_r  <= pc_next;
            if (offset_cap) begin
                offset_r <= offset_sext;
            end
            if (taken_cap) begin
                taken_r <= con_flag;
            end
        end
    end

    // Next-state, PC update and strobes; inc/load in the start cycle still apply, so the target is PC+1+C.
    always_comb begin
        state_next = state;
        pc_next    = pc_r;
        con_in     = 1'b0;
        busy       = 1'b1;
        br_done    = 1'b0;
        offset_cap = 1'b0;
        taken_cap  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (pc_load) begin
                    pc_next = busIn;
                end else if (pc_inc) begin
                    pc_next = pc_r + 32'd1;
                end
                if (br_start) begin
                    offset_cap = 1'b1;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                con_in     = 1'b1;
                state_next = SAMPLE;
            end
            SAMPLE: begin
                taken_cap  = 1'b1;
                state_next = UPDATE;
            end
            UPDATE: begin
                br_done = 1'b1;
                if (taken_r) begin
                    pc_next = pc_r + offset_r;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pc       = pc_r;
    assign br_taken = taken_r;

endmodule
